// File: rtl/mbist_mem_responder_if.sv
// Test bus between the BIST controller and the memory-side responder.
// The controller (master) drives address/op/data and the fault injector
// controls; the responder (slave) returns read data and status.
interface mbist_mem_responder_if #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 2
);
  localparam int unsigned FBW = (DW > 1) ? $clog2(DW) : 1;

  logic [AW-1:0]  tas_in;
  logic [CW-1:0]  tcs_in;
  logic [DW-1:0]  tds_in;
  logic           fault_en;
  logic [AW-1:0]  fault_addr;
  logic [FBW-1:0] fault_bit;
  logic           fault_val;
  logic [DW-1:0]  mem_out;
  logic           mem_valid;
  logic           init_busy;
  logic [15:0]    op_count;

  modport master (
    output tas_in, tcs_in, tds_in, fault_en, fault_addr, fault_bit, fault_val,
    input  mem_out, mem_valid, init_busy, op_count
  );

  modport slave (
    input  tas_in, tcs_in, tds_in, fault_en, fault_addr, fault_bit, fault_val,
    output mem_out, mem_valid, init_busy, op_count
  );
endinterface

// File: rtl/mbist_mem_responder.sv
// Memory-side BIST responder: executes TCS ops on an internal array, returns
// registered read data, and can inject a single stuck-at bit fault.
module mbist_mem_responder #(
  parameter int unsigned   AW       = 4,
  parameter int unsigned   DW       = 8,
  parameter int unsigned   CW       = 2,
  parameter logic [DW-1:0] INIT_VAL = '0
) (
  input logic                 clk,
  input logic                 rst,
  mbist_mem_responder_if.slave bus
);
  localparam int unsigned   FBW      = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [AW-1:0] LastAddr = '1;

  typedef enum logic {StInit, StReady} state_e;

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_ic;
  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] r_mem_out;
  logic          r_mem_valid;
  logic [15:0]   r_op_count;

  logic          w_init_busy;
  logic          w_do_read;
  logic          w_do_write;
  logic          w_do_count;
  logic          w_bit_ok;
  logic          w_fault_hit;
  logic [DW-1:0] w_wdata;
  logic [DW-1:0] w_rdata;
  logic [1:0]    w_op;

  assign w_op = bus.tcs_in[1:0];

  // A fault_bit field wide enough to exceed DW needs an explicit range check.
  if ((2 ** FBW) == DW) begin : g_full_bit_range
    assign w_bit_ok = 1'b1;
  end else begin : g_part_bit_range
    assign w_bit_ok = (32'(bus.fault_bit) < DW);
  end

  assign w_fault_hit = bus.fault_en && w_bit_ok && (bus.tas_in == bus.fault_addr);

  // Fault overrides one bit on both the write and read path of the faulty cell.
  always_comb begin
    w_wdata = bus.tds_in;
    w_rdata = r_mem[bus.tas_in];
    if (w_fault_hit) begin
      w_wdata[bus.fault_bit] = bus.fault_val;
      w_rdata[bus.fault_bit] = bus.fault_val;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= StInit;
    else      r_state <= w_state_next;
  end

  // Next state and per-cycle op decode.
  always_comb begin
    w_state_next = r_state;
    w_init_busy  = 1'b0;
    w_do_read    = 1'b0;
    w_do_write   = 1'b0;
    w_do_count   = 1'b0;
    unique case (r_state)
      StInit: begin
        w_init_busy = 1'b1;
        if (r_ic == LastAddr) w_state_next = StReady;
      end
      StReady: begin
        w_do_read  = w_op[1];
        w_do_write = w_op[0];
        w_do_count = (w_op != 2'b00);
      end
      default: w_state_next = StInit;
    endcase
  end

  // Initialisation write counter.
  always_ff @(posedge clk) begin
    if (!rst)             r_ic <= '0;
    else if (w_init_busy) r_ic <= r_ic + 1'b1;
  end

  // Array writes: INIT fill, then op writes. Contents are not reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_init_busy)     r_mem[r_ic]       <= INIT_VAL;
      else if (w_do_write) r_mem[bus.tas_in] <= w_wdata;
    end
  end

  // Registered read port and saturating op counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_mem_out   <= '0;
      r_mem_valid <= 1'b0;
      r_op_count  <= '0;
    end else begin
      r_mem_valid <= w_do_read;
      if (w_do_read) r_mem_out <= w_rdata;
      if (w_do_count && (r_op_count != 16'hFFFF)) r_op_count <= r_op_count + 16'd1;
    end
  end

  assign bus.mem_out   = r_mem_out;
  assign bus.mem_valid = r_mem_valid;
  assign bus.init_busy = w_init_busy;
  assign bus.op_count  = r_op_count;
endmodule
